// File: rtl/cpu_control_alu.sv
`default_nettype none
// ============================================================================
// Module      : cpu_control_alu
// Description : Control FSM, 8-bit ALU and next-PC mux for the 8-bit CPU.
//               Optional HALT state enabled by defining CTRL_HALT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_control_alu (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] irvalue,
  input  logic       zero,
  input  logic       negative,
  input  logic [7:0] dbus,
  input  logic [7:0] sbus,
  input  logic [7:0] imm,
  input  logic [7:0] pcadd,
  output logic [7:0] aluout,
  output logic [7:0] pcin,
  output logic       irload,
  output logic       imload,
  output logic       pcload,
  output logic       pcsel,
  output logic       readwrite,
  output logic       dwrite,
  output logic [1:0] dregsel,
  output logic [1:0] sregsel,
  output logic [1:0] aluop,
  output logic [1:0] regsel,
  output logic [1:0] addrsel
);

`ifdef CTRL_HALT_EN
  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_HALT   = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2
  } state_t;
`endif

  localparam logic [3:0] c_OP_ADD = 4'h1;
  localparam logic [3:0] c_OP_SUB = 4'h2;
  localparam logic [3:0] c_OP_AND = 4'h3;
  localparam logic [3:0] c_OP_OR  = 4'h4;
  localparam logic [3:0] c_OP_MOV = 4'h5;
  localparam logic [3:0] c_OP_LDI = 4'h6;
  localparam logic [3:0] c_OP_LD  = 4'h7;
  localparam logic [3:0] c_OP_ST  = 4'h8;
  localparam logic [3:0] c_OP_LDA = 4'h9;
  localparam logic [3:0] c_OP_JMP = 4'hA;
  localparam logic [3:0] c_OP_JZ  = 4'hB;
  localparam logic [3:0] c_OP_JN  = 4'hC;
`ifdef CTRL_HALT_EN
  localparam logic [3:0] c_OP_HLT = 4'hF;
`endif

  localparam logic [1:0] c_ALU_ADD = 2'b00;
  localparam logic [1:0] c_ALU_SUB = 2'b01;
  localparam logic [1:0] c_ALU_AND = 2'b10;
  localparam logic [1:0] c_ALU_OR  = 2'b11;

  state_t     r_state;
  state_t     w_next_state;
  logic [3:0] w_op;
  logic [1:0] w_d;
  logic [1:0] w_s;
  logic       w_two_byte;

  assign w_op = irvalue[7:4];
  assign w_d  = irvalue[3:2];
  assign w_s  = irvalue[1:0];

  assign w_two_byte = (w_op == c_OP_LDI) || (w_op == c_OP_ST)  || (w_op == c_OP_LDA) ||
                      (w_op == c_OP_JMP) || (w_op == c_OP_JZ)  || (w_op == c_OP_JN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH:  w_next_state = S_DECODE;
      S_DECODE: w_next_state = S_EXEC;
      S_EXEC: begin
        w_next_state = S_FETCH;
`ifdef CTRL_HALT_EN
        if (w_op == c_OP_HLT) begin
          w_next_state = S_HALT;
        end
`endif
      end
`ifdef CTRL_HALT_EN
      S_HALT:   w_next_state = S_HALT;
`endif
      default:  w_next_state = S_FETCH;
    endcase
  end

  // Outputs are held idle while reset is low, even though the state reads FETCH.
  always_comb begin
    irload    = 1'b0;
    imload    = 1'b0;
    pcload    = 1'b0;
    pcsel     = 1'b1;
    readwrite = 1'b0;
    dwrite    = 1'b0;
    dregsel   = 2'd0;
    sregsel   = 2'd0;
    aluop     = c_ALU_ADD;
    regsel    = 2'd0;
    addrsel   = 2'd0;
    if (rst_n) begin
      case (r_state)
        S_FETCH: begin
          irload = 1'b1;
          pcload = 1'b1;
        end
        S_DECODE: begin
          if (w_two_byte) begin
            imload = 1'b1;
            pcload = 1'b1;
          end
        end
        S_EXEC: begin
          dregsel = w_d;
          sregsel = w_s;
          case (w_op)
            c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR: begin
              aluop  = w_op[1:0] - 2'd1;
              regsel = 2'd3;
              dwrite = 1'b1;
            end
            c_OP_MOV: begin
              regsel = 2'd1;
              dwrite = 1'b1;
            end
            c_OP_LDI: begin
              regsel = 2'd0;
              dwrite = 1'b1;
            end
            c_OP_LD: begin
              addrsel = 2'd2;
              regsel  = 2'd2;
              dwrite  = 1'b1;
            end
            c_OP_ST: begin
              // Route d through both ALU ports so AND returns d as write data.
              sregsel   = w_d;
              aluop     = c_ALU_AND;
              addrsel   = 2'd1;
              readwrite = 1'b1;
            end
            c_OP_LDA: begin
              addrsel = 2'd1;
              regsel  = 2'd2;
              dwrite  = 1'b1;
            end
            c_OP_JMP: begin
              pcsel  = 1'b0;
              pcload = 1'b1;
            end
            c_OP_JZ: begin
              pcsel  = 1'b0;
              pcload = zero;
            end
            c_OP_JN: begin
              pcsel  = 1'b0;
              pcload = negative;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (aluop)
      c_ALU_ADD: aluout = dbus + sbus;
      c_ALU_SUB: aluout = dbus - sbus;
      c_ALU_AND: aluout = dbus & sbus;
      c_ALU_OR:  aluout = dbus | sbus;
      default:   aluout = 8'd0;
    endcase
  end

  assign pcin = pcsel ? pcadd : imm;

endmodule
`default_nettype wire

// File: tb/tb_cpu_control_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_control_alu
// Description : Self-checking bench for cpu_control_alu against a phase model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_control_alu;

  typedef struct packed {
    logic       irload;
    logic       imload;
    logic       pcload;
    logic       pcsel;
    logic       readwrite;
    logic       dwrite;
    logic [1:0] dregsel;
    logic [1:0] sregsel;
    logic [1:0] aluop;
    logic [1:0] regsel;
    logic [1:0] addrsel;
  } ctrl_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] irvalue;
  logic       zero;
  logic       negative;
  logic [7:0] dbus;
  logic [7:0] sbus;
  logic [7:0] imm;
  logic [7:0] pcadd;
  logic [7:0] aluout;
  logic [7:0] pcin;
  logic       irload;
  logic       imload;
  logic       pcload;
  logic       pcsel;
  logic       readwrite;
  logic       dwrite;
  logic [1:0] dregsel;
  logic [1:0] sregsel;
  logic [1:0] aluop;
  logic [1:0] regsel;
  logic [1:0] addrsel;

  int compared   = 0;
  int mismatched = 0;
  int ph         = 0;   // 0 fetch, 1 decode, 2 exec, 3 halted
  bit need_tick  = 1'b1;

  cpu_control_alu dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .irvalue   (irvalue),
    .zero      (zero),
    .negative  (negative),
    .dbus      (dbus),
    .sbus      (sbus),
    .imm       (imm),
    .pcadd     (pcadd),
    .aluout    (aluout),
    .pcin      (pcin),
    .irload    (irload),
    .imload    (imload),
    .pcload    (pcload),
    .pcsel     (pcsel),
    .readwrite (readwrite),
    .dwrite    (dwrite),
    .dregsel   (dregsel),
    .sregsel   (sregsel),
    .aluop     (aluop),
    .regsel    (regsel),
    .addrsel   (addrsel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic ctrl_t actual();
    ctrl_t a;
    a = '{irload, imload, pcload, pcsel, readwrite, dwrite,
          dregsel, sregsel, aluop, regsel, addrsel};
    return a;
  endfunction

  // Expected control word, written directly from the instruction table.
  function automatic ctrl_t model(input int p, input logic [7:0] ir,
                                  input logic z, input logic n, input logic rn);
    ctrl_t o;
    int    op;
    o       = '0;
    o.pcsel = 1'b1;
    op      = int'(ir[7:4]);
    if (!rn) return o;
    if (p == 0) begin
      o.irload = 1'b1;
      o.pcload = 1'b1;
    end else if (p == 1) begin
      if (op == 6 || op == 8 || op == 9 || op == 10 || op == 11 || op == 12) begin
        o.imload = 1'b1;
        o.pcload = 1'b1;
      end
    end else if (p == 2) begin
      o.dregsel = ir[3:2];
      o.sregsel = ir[1:0];
      if (op >= 1 && op <= 4) begin
        o.aluop  = 2'(op - 1);
        o.regsel = 2'd3;
        o.dwrite = 1'b1;
      end else if (op == 5) begin
        o.regsel = 2'd1; o.dwrite = 1'b1;
      end else if (op == 6) begin
        o.regsel = 2'd0; o.dwrite = 1'b1;
      end else if (op == 7) begin
        o.addrsel = 2'd2; o.regsel = 2'd2; o.dwrite = 1'b1;
      end else if (op == 8) begin
        o.sregsel = ir[3:2]; o.aluop = 2'b10; o.addrsel = 2'd1; o.readwrite = 1'b1;
      end else if (op == 9) begin
        o.addrsel = 2'd1; o.regsel = 2'd2; o.dwrite = 1'b1;
      end else if (op == 10) begin
        o.pcsel = 1'b0; o.pcload = 1'b1;
      end else if (op == 11) begin
        o.pcsel = 1'b0; o.pcload = z;
      end else if (op == 12) begin
        o.pcsel = 1'b0; o.pcload = n;
      end
    end
    return o;
  endfunction

  function automatic logic [7:0] ref_alu(input logic [1:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    int r;
    case (op)
      2'd0:    r = int'(a) + int'(b);
      2'd1:    r = int'(a) - int'(b) + 256;
      2'd2:    r = int'(a & b);
      default: r = int'(a | b);
    endcase
    return 8'(r % 256);
  endfunction

  function automatic int next_ph(input int p, input logic [7:0] ir);
    if (p == 3) return 3;
    if (p == 2) begin
`ifdef CTRL_HALT_EN
      if (ir[7:4] == 4'hF) return 3;
`endif
      return 0;
    end
    return p + 1;
  endfunction

  task automatic check_all();
    ctrl_t e;
    e = model(ph, irvalue, zero, negative, rst_n);
    chk("ctrl", 16'(actual()), 16'(e));
    chk("aluout", {8'd0, aluout}, {8'd0, ref_alu(e.aluop, dbus, sbus)});
    chk("pcin", {8'd0, pcin}, {8'd0, (e.pcsel ? pcadd : imm)});
  endtask

  // One clock cycle: drive after the falling edge, check, then advance the model.
  task automatic step(input logic [7:0] ir, input logic z, input logic n,
                      input logic [7:0] d, input logic [7:0] s, input logic [7:0] im);
    if (need_tick) @(negedge clk);
    need_tick = 1'b1;
    irvalue  = ir;
    zero     = z;
    negative = n;
    dbus     = d;
    sbus     = s;
    imm      = im;
    pcadd    = 8'($urandom);
    #1;
    check_all();
    ph = next_ph(ph, ir);
  endtask

  task automatic run_instr(input logic [7:0] ir, input logic z, input logic n,
                           input logic [7:0] d, input logic [7:0] s, input logic [7:0] im);
    repeat (3) step(ir, z, n, d, s, im);
  endtask

  task automatic do_reset();
    if (need_tick) @(negedge clk);
    rst_n = 1'b0;
    #1;
    ph = 0;
    check_all();
    chk("rst_strobes", {11'd0, irload, imload, pcload, dwrite, readwrite}, 16'd0);
    @(negedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n     = 1'b1;
    need_tick = 1'b0;
  endtask

  initial begin
    logic [7:0] r_ir;
    rst_n = 1'b0; irvalue = 8'h00; zero = 1'b0; negative = 1'b0;
    dbus = 8'h00; sbus = 8'h00; imm = 8'h00; pcadd = 8'h01;

    do_reset();
    step(8'h16, 1'b0, 1'b0, 8'hF0, 8'h20, 8'h55);
    chk("first_fetch", {12'd0, irload, pcload, pcsel, 1'b0}, 16'b1110);
    chk("first_addrsel", {14'd0, addrsel}, 16'd0);

    // ADD r1,r2 with wrapping operands
    step(8'h16, 1'b0, 1'b0, 8'hF0, 8'h20, 8'h55);
    chk("add_dec_imload", {15'd0, imload}, 16'd0);
    step(8'h16, 1'b0, 1'b0, 8'hF0, 8'h20, 8'h55);
    chk("add_exec_fields", {7'd0, aluop, regsel, dwrite, dregsel, sregsel},
        {7'd0, 2'b00, 2'd3, 1'b1, 2'd1, 2'd2});
    chk("alu_add_wrap", {8'd0, aluout}, 16'h0010);

    run_instr(8'h26, 1'b0, 1'b0, 8'hF0, 8'h20, 8'h00);
    chk("alu_sub", {8'd0, aluout}, 16'h00D0);
    run_instr(8'h36, 1'b0, 1'b0, 8'hF0, 8'h20, 8'h00);
    chk("alu_and", {8'd0, aluout}, 16'h0020);
    run_instr(8'h46, 1'b0, 1'b0, 8'hF0, 8'h20, 8'h00);
    chk("alu_or", {8'd0, aluout}, 16'h00F0);
    run_instr(8'h26, 1'b0, 1'b0, 8'h00, 8'h01, 8'h00);
    chk("alu_sub_under", {8'd0, aluout}, 16'h00FF);

    // LDI r3,#imm
    step(8'h6C, 1'b0, 1'b0, 8'h00, 8'h00, 8'h3A);
    step(8'h6C, 1'b0, 1'b0, 8'h00, 8'h00, 8'h3A);
    chk("ldi_decode", {14'd0, imload, pcload}, 16'b11);
    step(8'h6C, 1'b0, 1'b0, 8'h00, 8'h00, 8'h3A);
    chk("ldi_exec", {11'd0, regsel, dwrite, dregsel}, {11'd0, 2'd0, 1'b1, 2'd3});

    // JZ r0 taken and not taken
    run_instr(8'hB0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h9C);
    chk("jz_taken", {7'd0, pcload, pcin}, {7'd0, 1'b1, 8'h9C});
    run_instr(8'hB0, 1'b0, 1'b0, 8'h05, 8'h00, 8'h9C);
    chk("jz_not_taken", {15'd0, pcload}, 16'd0);

    // ST r2,[#imm]
    run_instr(8'h88, 1'b0, 1'b0, 8'h5A, 8'h5A, 8'h40);
    chk("st_exec", {9'd0, readwrite, addrsel, sregsel, aluop},
        {9'd0, 1'b1, 2'd1, 2'd2, 2'b10});
    chk("st_data", {8'd0, aluout}, 16'h005A);

    // Randomized instruction stream, with a reset dropped in mid-instruction
    for (int i = 0; i < 200; i++) begin
      r_ir = {4'($urandom_range(0, 14)), 4'($urandom)};
      for (int c = 0; c < 3; c++) begin
        if (i == 120 && c == 1) begin
          do_reset();
          break;
        end
        step(r_ir, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      end
    end

    // HLT
    run_instr(8'hF0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
`ifdef CTRL_HALT_EN
    for (int i = 0; i < 10; i++) begin
      step(8'($urandom), 1'b1, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
      chk("halt_strobes", {11'd0, irload, imload, pcload, dwrite, readwrite}, 16'd0);
    end
`else
    step(8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    chk("hlt_as_nop_fetch", {14'd0, irload, pcload}, 16'b11);
`endif
    do_reset();
    step(8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    chk("refetch_after_reset", {15'd0, irload}, 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
